// File: rtl/bitserial_pkg.sv
// Shared types and width helpers for the bit-serial MAC engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitserial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Width of the adder-tree output: one extra bit per tree level.
  function automatic int psum_width(input int data_width, input int vec_length);
    return data_width + $clog2(vec_length);
  endfunction

  // Width of the column index / precision field.
  function automatic int col_width(input int w_prec);
    return (w_prec > 2) ? $clog2(w_prec) : 1;
  endfunction

endpackage

// File: rtl/bs_adder_tree.sv
// Signed binary adder tree reducing VEC_LENGTH lanes to one partial sum.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the operands directly.
module bs_adder_tree
  import bitserial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]                 operand,
  output logic signed [psum_width(DATA_WIDTH, VEC_LENGTH)-1:0]  psum
);

  localparam int LEVELS = $clog2(VEC_LENGTH);

  // Level l holds VEC_LENGTH>>l nodes of DATA_WIDTH+l bits; each add grows by
  // one bit so no level can overflow.
  genvar l, n;
  generate
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int W = DATA_WIDTH + l;
      localparam int N = VEC_LENGTH >> l;
      logic signed [W-1:0] node [N];
      if (l == 0) begin : g_leaf
        for (n = 0; n < N; n++) begin : g_n
          assign node[n] = operand[n];
        end
      end else begin : g_add
        for (n = 0; n < N; n++) begin : g_n
          assign node[n] = {g_lvl[l-1].node[2*n][W-2],   g_lvl[l-1].node[2*n]}
                         + {g_lvl[l-1].node[2*n+1][W-2], g_lvl[l-1].node[2*n+1]};
        end
      end
    end
  endgenerate

  assign psum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/bitserial_mac_seq.sv
// Bit-serial dot-product engine accumulating prec+1 weight columns per group.
// Latency: result/out_valid register one cycle after the last beat is accepted.
// Backpressure: in_ready = ~out_valid | out_ready; input stalls while a result is unconsumed.
module bitserial_mac_seq
  import bitserial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int W_PREC     = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in,
  input  logic [VEC_LENGTH-1:0]                w_bit,
  input  logic [col_width(W_PREC)-1:0]         prec,
  input  logic                                 w_signed,
  input  logic                                 load_accum,
  input  logic [ACC_WIDTH-1:0]                 accum_prev,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_WIDTH-1:0]                 result
);

  localparam int PW = psum_width(DATA_WIDTH, VEC_LENGTH);
  localparam int CW = col_width(W_PREC);

  state_t                       state;
  logic [CW-1:0]                col;
  logic [CW-1:0]                prec_q;
  logic                         w_signed_q;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] lane_sel;
  logic signed [PW-1:0]         psum;
  logic signed [PW:0]           psum_ext;
  logic signed [PW:0]           col_val;
  logic signed [ACC_WIDTH-1:0]  col_ext;
  logic signed [ACC_WIDTH-1:0]  term;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic [CW-1:0]                cur_prec;
  logic                         cur_signed;
  logic                         last;
  logic                         accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~clear;

  // Gate each lane's activation by its weight bit for this column.
  always_comb begin
    lane_sel = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      lane_sel[j] = w_bit[j] ? act_in[j] : '0;
    end
  end

  bs_adder_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH)
  ) u_tree (
    .operand (lane_sel),
    .psum    (psum)
  );

  // Column term: the MSB column of a signed weight carries negative weight,
  // and on the first beat the precision/sign come straight from the inputs.
  always_comb begin
    cur_prec   = (state == IDLE) ? prec : prec_q;
    cur_signed = (state == IDLE) ? w_signed : w_signed_q;
    last       = (col == cur_prec);
    psum_ext   = {psum[PW-1], psum};
    col_val    = (last && cur_signed) ? -psum_ext : psum_ext;
    col_ext    = ACC_WIDTH'(col_val);
    term       = col_ext << col;
    if (state == IDLE) begin
      base = load_accum ? accum_prev : '0;
    end else begin
      base = acc;
    end
    sum = base + term;
  end

  // Group FSM, accumulator and registered result/out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      col        <= '0;
      prec_q     <= '0;
      w_signed_q <= 1'b0;
      acc        <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        state <= IDLE;
        col   <= '0;
        acc   <= '0;
      end else if (accept) begin
        acc <= sum;
        if (state == IDLE) begin
          prec_q     <= prec;
          w_signed_q <= w_signed;
        end
        if (last) begin
          result    <= sum;
          out_valid <= 1'b1;
          col       <= '0;
          state     <= IDLE;
        end else begin
          col   <= col + 1'b1;
          state <= ACC;
        end
      end
    end
  end

endmodule

// File: doc/bitserial_mac_seq.md
# bitserial_mac_seq

Parametrised bit-serial (Stripes-style) dot-product engine. Each cycle it consumes one weight bit-column across a VEC_LENGTH activation vector, reduces it with an adder tree, and shifts by the column index. Unlike the single-column unit, it accumulates internally over a runtime-selectable number of columns, supports signed and unsigned weights, and presents a registered result through valid/ready handshakes. It sits between the activation/weight-bit streamer and the output writeback buffer.

## Interface
- DATA_WIDTH, 8, activation width (signed)
- VEC_LENGTH, 16, lanes per column; power of 2, ≥2
- W_PREC, 8, maximum weight precision in bits (2..16)
- ACC_WIDTH, DATA_WIDTH+16, accumulator and result width
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- clear  in  1  synchronous abort of the current group
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- act_in  in  DATA_WIDTH × VEC_LENGTH  signed activations for this beat
- w_bit  in  VEC_LENGTH  weight bit for this column, per lane
- prec  in  $clog2(W_PREC)  number of columns minus 1; sampled on the first beat of a group
- w_signed  in  1  1 = two's-complement weights; sampled on the first beat
- load_accum  in  1  on the first beat, seed with accum_prev instead of 0
- accum_prev  in  ACC_WIDTH  signed seed value
- out_valid  out  1  result holds a completed group
- out_ready  in  1  consumer accepts result
- result  out  ACC_WIDTH  signed dot product

## Operation
- FSM states: IDLE (no group open, col=0) and ACC (group open, col = next column index).
- The term for each beat is computed as follows:
  - Each lane contributes act_in[j] when w_bit[j] is 1, else 0.
  - Lanes are summed by the adder tree to a signed psum of DATA_WIDTH+log2(VEC_LENGTH) bits.
  - psum is sign-extended by 1 bit, then negated when the column is the last one (col==prec_q) and w_signed_q=1.
  - The value is shifted left by col and sign-extended to ACC_WIDTH.
- IDLE, accepted beat:
  - Latch prec_q=prec and w_signed_q=w_signed.
  - acc ← (load_accum ? accum_prev : 0) + term(col=0).
  - If prec==0, this beat is also the last one (see below). Otherwise col←1 and go to ACC.
- ACC, accepted beat:
  - acc ← acc + term.
  - If col==prec_q, this is the last beat: result ← acc + term, out_valid←1, col←0, go to IDLE. Otherwise col←col+1.
- Arithmetic is two's complement and wraps modulo 2^ACC_WIDTH. There is no saturation.
- in_ready = ~out_valid | out_ready, i.e. the whole input stalls while an unconsumed result is held.
- out_valid is cleared when out_valid & out_ready, unless a last beat is accepted in the same cycle, in which case it stays 1 with the new result.
- clear=1 sets col←0, acc←0 and returns to IDLE. Any beat in the same cycle is discarded. out_valid and result are unaffected.
- When w_signed=0 and prec=0, the result is the plain sum of the selected activations.

## Timing
- Reset values: result=0, out_valid=0, acc=0, col=0, state=IDLE. in_ready=1 after reset.
- Latency: result and out_valid are valid the cycle after the last beat is accepted.
- Throughput: one column per cycle. Groups run back-to-back with no bubble when out_ready=1.
- A group of N=prec+1 columns occupies exactly N accepted beats. Stalled cycles do not advance col.
- Reset asserted mid-group discards the group immediately. The first beat after release starts a new group.
- result is stable while out_valid & ~out_ready.
- in_ready depends combinationally on out_valid and out_ready only.

## Structure
- Package bitserial_pkg holds:
  - the state enum {IDLE, ACC};
  - a function psum_width(DATA_WIDTH, VEC_LENGTH);
  - a function col_width(W_PREC).
- Sub-module bs_adder_tree:
  - purely combinational, with a generate-built log2(VEC_LENGTH)-level tree;
  - parametrised by DATA_WIDTH and VEC_LENGTH;
  - each level grows 1 bit.
- The top level holds the lane select, negate/shift, accumulator, FSM and output register.

## Test plan
All scenarios use defaults (8, 16, 8, 24).
- Unsigned basic: all act=1, weight=1 in all lanes, prec=7, w_signed=0, 8 beats → result=16, out_valid one cycle after beat 8.
- Signed negative: act=3, weight=-1 (all 8 bits 1), w_signed=1 → result=-48. Repeat with weight=-128 and act=-128 → result=262144 (checks negation of psum=-2048).
- Single-column mode: prec=0, w_signed=1, act=5, w_bit=1 in all lanes → result=-80 after one beat. Same with w_signed=0 → result=80.
- Seed: load_accum=1, accum_prev=1000, then the unsigned-basic stimulus → result=1016. Back-to-back second group without seed → 16, no bubble.
- Backpressure: out_ready=0 after group 1 completes → in_ready=0, result held for 5 cycles. Raise out_ready → group 2 beats accepted and result correct.
- Abort: reset low after beat 3 → out_valid=0, result=0. clear after beat 5 of a new group → the following full group yields its exact value with no residue.
